// File: rtl/uart_decrypt_rx_buffer.sv
// rtl/uart_decrypt_rx_buffer.sv - XOR-decrypting UART receive buffer with FWFT FIFO and error status
module uart_decrypt_rx_buffer #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 2,
  parameter int ERR_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [2:0]        BAUD_SELECT,
  input  logic [7:0]        RX_DATA,
  input  logic              RX_VALID,
  input  logic              RX_FERROR,
  input  logic              RX_PERROR,
  output logic [7:0]        DATA_OUT,
  output logic              DATA_VALID,
  input  logic              DATA_READY,
  output logic [ADDR_W:0]   FIFO_COUNT,
  output logic              OVERFLOW,
  output logic [ERR_W-1:0]  ERR_COUNT,
  input  logic              STATUS_CLR
);

  logic [7:0]        mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W-1:0] rd_next;
  logic [ADDR_W:0]   count;
  logic [ADDR_W:0]   count_next;
  logic [7:0]        mask;
  logic [7:0]        wdata;
  logic [7:0]        head_next;
  logic              pop;
  logic              full;
  logic              err_evt;
  logic              push;
  logic              ovf_evt;

  // Key mask and per-cycle push/pop/drop decisions; errors outrank the full check
  always_comb begin
    mask       = {BAUD_SELECT[1:0], BAUD_SELECT, BAUD_SELECT};
    wdata      = RX_DATA ^ mask;
    full       = (count == (ADDR_W+1)'(DEPTH));
    pop        = (count != '0) && DATA_READY;
    err_evt    = RX_VALID && (RX_FERROR || RX_PERROR);
    push       = RX_VALID && !err_evt && (!full || pop);
    ovf_evt    = RX_VALID && !err_evt && full && !pop;
    rd_next    = pop ? rd_ptr + ADDR_W'(1) : rd_ptr;
    count_next = count;
    if (push && !pop) count_next = count + (ADDR_W+1)'(1);
    if (pop && !push) count_next = count - (ADDR_W+1)'(1);
    // The new byte becomes the head only when it is the sole entry after this edge
    head_next  = (push && (rd_next == wr_ptr)) ? wdata : mem[rd_next];
  end

  // Storage array; contents survive reset, only the pointers are cleared
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  // Pointers, occupancy and registered head byte (held while empty)
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      DATA_OUT <= 8'h00;
    end else begin
      if (push) wr_ptr <= wr_ptr + ADDR_W'(1);
      rd_ptr <= rd_next;
      count  <= count_next;
      if (count_next != '0) DATA_OUT <= head_next;
    end
  end

  // Sticky overflow and saturating error counter; a same-cycle event beats the clear
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      OVERFLOW  <= 1'b0;
      ERR_COUNT <= '0;
    end else begin
      if (ovf_evt)         OVERFLOW <= 1'b1;
      else if (STATUS_CLR) OVERFLOW <= 1'b0;
      if (err_evt) begin
        if (STATUS_CLR)            ERR_COUNT <= ERR_W'(1);
        else if (ERR_COUNT != '1) ERR_COUNT <= ERR_COUNT + ERR_W'(1);
      end else if (STATUS_CLR) begin
        ERR_COUNT <= '0;
      end
    end
  end

  assign DATA_VALID = (count != '0);
  assign FIFO_COUNT = count;

endmodule

// File: tb/tb_uart_decrypt_rx_buffer.sv
// tb/tb_uart_decrypt_rx_buffer.sv - scoreboard bench for uart_decrypt_rx_buffer
module tb_uart_decrypt_rx_buffer;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] BAUD_SELECT = '0;
  logic [7:0] RX_DATA = '0;
  logic       RX_VALID = 1'b0;
  logic       RX_FERROR = 1'b0;
  logic       RX_PERROR = 1'b0;
  logic [7:0] DATA_OUT;
  logic       DATA_VALID;
  logic       DATA_READY = 1'b0;
  logic [2:0] FIFO_COUNT;
  logic       OVERFLOW;
  logic [7:0] ERR_COUNT;
  logic       STATUS_CLR = 1'b0;

  uart_decrypt_rx_buffer #(.DEPTH(4), .ADDR_W(2), .ERR_W(8)) dut (
    .clk(clk), .reset(reset), .BAUD_SELECT(BAUD_SELECT), .RX_DATA(RX_DATA),
    .RX_VALID(RX_VALID), .RX_FERROR(RX_FERROR), .RX_PERROR(RX_PERROR),
    .DATA_OUT(DATA_OUT), .DATA_VALID(DATA_VALID), .DATA_READY(DATA_READY),
    .FIFO_COUNT(FIFO_COUNT), .OVERFLOW(OVERFLOW), .ERR_COUNT(ERR_COUNT),
    .STATUS_CLR(STATUS_CLR)
  );

  always #5 clk = ~clk;

  int         n_chk = 0;
  int         n_fail = 0;
  bit         started = 0;
  logic [7:0] q[$];
  logic [7:0] exp_last = 8'h00;
  bit         m_ovf = 0;
  int         m_err = 0;
  bit         pend_push = 0, pend_ovf = 0, pend_err = 0, pend_clr = 0;
  logic [7:0] pend_data = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] key(input logic [2:0] b);
    int bi;
    bi = int'(b);
    return 8'((bi % 4) * 64 + bi * 8 + bi);
  endfunction

  task automatic commit();
    if (pend_push) q.push_back(pend_data);
    if (pend_ovf) m_ovf = 1;
    else if (pend_clr) m_ovf = 0;
    if (pend_err) m_err = pend_clr ? 1 : (m_err == 255 ? 255 : m_err + 1);
    else if (pend_clr) m_err = 0;
    pend_push = 0; pend_ovf = 0; pend_err = 0; pend_clr = 0;
  endtask

  task automatic cycle(input bit v, input logic [7:0] d, input bit f, input bit p,
                       input logic [2:0] b, input bit r, input bit c);
    bit pop_now, err_now, room;
    @(posedge clk);
    commit();
    #1;
    RX_VALID = v; RX_DATA = d; RX_FERROR = f; RX_PERROR = p;
    BAUD_SELECT = b; DATA_READY = r; STATUS_CLR = c;
    pop_now   = (q.size() != 0) && r;
    err_now   = v && (f || p);
    room      = (q.size() < DEPTH) || pop_now;
    pend_push = v && !err_now && room;
    pend_ovf  = v && !err_now && !room;
    pend_err  = err_now;
    pend_clr  = c;
    pend_data = d ^ key(b);
  endtask

  task automatic idle(input bit r);
    cycle(0, 8'h00, 0, 0, 3'b000, r, 0);
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  // Monitor: compare DUT outputs with the scoreboard and retire popped bytes
  always @(negedge clk) begin
    if (started) begin
      chk("valid", 32'(DATA_VALID), 32'(q.size() != 0));
      chk("count", 32'(FIFO_COUNT), 32'(q.size()));
      chk("overflow", 32'(OVERFLOW), 32'(m_ovf));
      chk("err_count", 32'(ERR_COUNT), 32'(m_err));
      if (q.size() != 0) begin
        chk("data_out", 32'(DATA_OUT), 32'(q[0]));
        exp_last = q[0];
        if (DATA_READY) void'(q.pop_front());
      end else begin
        chk("data_hold", 32'(DATA_OUT), 32'(exp_last));
      end
    end
  end

  initial begin
    repeat (2) @(posedge clk);
    #2;
    chk("rst_valid", 32'(DATA_VALID), 32'd0);
    chk("rst_count", 32'(FIFO_COUNT), 32'd0);
    chk("rst_data", 32'(DATA_OUT), 32'h00);
    chk("rst_ovf", 32'(OVERFLOW), 32'd0);
    chk("rst_err", 32'(ERR_COUNT), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    started = 1;

    // Single byte decrypt with key 101
    cycle(1, 8'h2C, 0, 0, 3'b101, 0, 0);
    idle(0);
    settle();
    chk("t1_data", 32'(DATA_OUT), 32'h41);
    chk("t1_count", 32'(FIFO_COUNT), 32'd1);
    idle(1);
    idle(0);
    settle();
    chk("t1_empty", 32'(DATA_VALID), 32'd0);

    // Fill, overflow, drain in order across pointer wrap
    for (int i = 1; i <= 4; i++) cycle(1, 8'(i * 17), 0, 0, 3'b000, 0, 0);
    cycle(1, 8'h55, 0, 0, 3'b000, 0, 0);
    idle(0);
    settle();
    chk("t2_count", 32'(FIFO_COUNT), 32'd4);
    chk("t2_ovf", 32'(OVERFLOW), 32'd1);
    repeat (5) idle(1);

    // Full FIFO with simultaneous push and pop
    cycle(0, 8'h00, 0, 0, 3'b000, 0, 1);
    for (int i = 1; i <= 4; i++) cycle(1, 8'(i), 0, 0, 3'b000, 0, 0);
    cycle(1, 8'h66, 0, 0, 3'b000, 1, 0);
    idle(0);
    settle();
    chk("t3_count", 32'(FIFO_COUNT), 32'd4);
    chk("t3_ovf", 32'(OVERFLOW), 32'd0);
    repeat (5) idle(1);

    // Error drops on a full FIFO, saturation, clear, clear-vs-event
    for (int i = 0; i < 4; i++) cycle(1, 8'(i + 8'h70), 0, 0, 3'b010, 0, 0);
    cycle(1, 8'h99, 0, 1, 3'b000, 0, 0);
    idle(0);
    settle();
    chk("t4_err1", 32'(ERR_COUNT), 32'd1);
    chk("t4_ovf", 32'(OVERFLOW), 32'd0);
    for (int i = 0; i < 300; i++) cycle(1, 8'(i), (i % 2) == 0, (i % 3) == 0 || (i % 2) == 1, 3'b000, 0, 0);
    idle(0);
    settle();
    chk("t4_sat", 32'(ERR_COUNT), 32'hFF);
    cycle(0, 8'h00, 0, 0, 3'b000, 0, 1);
    idle(0);
    settle();
    chk("t4_clr", 32'(ERR_COUNT), 32'd0);
    cycle(1, 8'h00, 1, 0, 3'b000, 0, 1);
    idle(0);
    settle();
    chk("t4_clr_evt", 32'(ERR_COUNT), 32'd1);
    repeat (5) idle(1);

    // Key sampled at write time, not at read time
    cycle(1, 8'hA5, 0, 0, 3'b111, 0, 0);
    idle(0);
    settle();
    chk("t5_data", 32'(DATA_OUT), 32'h5A);
    idle(1);

    // Asynchronous reset mid-stream
    for (int i = 0; i < 3; i++) cycle(1, 8'(8'hC0 + i), 0, 0, 3'b011, 0, 0);
    idle(0);
    @(posedge clk);
    commit();
    #2;
    reset = 1'b1;
    #1;
    chk("t6_valid", 32'(DATA_VALID), 32'd0);
    chk("t6_count", 32'(FIFO_COUNT), 32'd0);
    q.delete();
    m_ovf = 0; m_err = 0; exp_last = 8'h00;
    pend_push = 0; pend_ovf = 0; pend_err = 0; pend_clr = 0;
    @(negedge clk);
    #2;
    reset = 1'b0;
    repeat (4) idle(1);
    settle();
    chk("t6_quiet", 32'(DATA_VALID), 32'd0);

    // Randomized traffic against the scoreboard
    for (int i = 0; i < 600; i++) begin
      cycle($urandom_range(0, 1) == 1, 8'($urandom), $urandom_range(0, 9) == 0,
            $urandom_range(0, 9) == 0, 3'($urandom), $urandom_range(0, 2) != 0,
            $urandom_range(0, 19) == 0);
    end
    repeat (8) idle(1);
    settle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_decrypt_rx_buffer.md
Name: uart_decrypt_rx_buffer

Overview:
- Receive-side counterpart of the transmit-path XOR encryptor.
- Accepts byte strobes from the UART receiver and decrypts each byte with the key mask derived from BAUD_SELECT.
- Drops bytes flagged with framing or parity errors.
- Buffers good bytes in a small FIFO and presents them to the LED driver through a valid/ready handshake.

Parameters:
- DEPTH, 4, FIFO entries (power of two, 2..16).
- ADDR_W, 2, log2(DEPTH).
- ERR_W, 8, width of the saturating error counter.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- BAUD_SELECT  input  3  decryption key; same value the transmitter used as its encryption key.
- RX_DATA  input  8  encrypted byte from the UART receiver.
- RX_VALID  input  1  one-cycle strobe; RX_DATA, RX_FERROR and RX_PERROR are valid while it is high.
- RX_FERROR  input  1  framing error for the strobed byte.
- RX_PERROR  input  1  parity error for the strobed byte.
- DATA_OUT  output  8  decrypted byte at the FIFO head.
- DATA_VALID  output  1  high while the FIFO is non-empty.
- DATA_READY  input  1  consumer accepts the head byte when DATA_VALID && DATA_READY.
- FIFO_COUNT  output  ADDR_W+1  current occupancy, 0..DEPTH.
- OVERFLOW  output  1  sticky: a good byte was dropped because the FIFO was full.
- ERR_COUNT  output  ERR_W  saturating count of error-dropped bytes.
- STATUS_CLR  input  1  synchronous clear of OVERFLOW and ERR_COUNT.

Behaviour:
- Reset (async, high) forces:
  - DATA_VALID=0, FIFO_COUNT=0, OVERFLOW=0, ERR_COUNT=0, DATA_OUT=8'h00.
  - Read and write pointers to 0.
  - FIFO contents need not be cleared.
  - Reset asserted mid-stream discards all buffered bytes; nothing is emitted after release until a new RX_VALID.
- Key mask: MASK = {BAUD_SELECT[1:0], BAUD_SELECT, BAUD_SELECT}. Decrypted byte = RX_DATA ^ MASK.
  - BAUD_SELECT is sampled in the RX_VALID cycle. Bytes already stored keep the key they were written with.
- Write rules, evaluated on each RX_VALID cycle:
  - RX_FERROR or RX_PERROR high: byte dropped; ERR_COUNT increments, saturating at all-ones. The error check takes priority over the full check.
  - Otherwise, not full, or full with a pop in the same cycle: the decrypted byte is written at the write pointer, and the pointer increments modulo DEPTH.
  - Otherwise (full, no pop): byte dropped; OVERFLOW set to 1.
- Read rules:
  - DATA_VALID = (FIFO_COUNT != 0).
  - DATA_OUT is the memory entry at the read pointer (first-word fall-through). While empty, DATA_OUT holds its last value (8'h00 after reset).
  - A pop (DATA_VALID && DATA_READY) increments the read pointer modulo DEPTH.
  - DATA_READY while empty has no effect.
- Latency: a good byte strobed in cycle N into an empty FIFO appears with DATA_VALID=1 in cycle N+1.
- Count update:
  - push only: +1.
  - pop only: -1.
  - push and pop together: unchanged.
  - Push and pop in the same cycle while empty is impossible, because no pop exists when empty.
- Pointer wrap: both pointers wrap from DEPTH-1 to 0. Full is FIFO_COUNT==DEPTH; empty is FIFO_COUNT==0.
- STATUS_CLR: clears OVERFLOW and ERR_COUNT on the next edge.
  - If an overflow or error drop happens in the same cycle, the new event wins: OVERFLOW=1, or ERR_COUNT=1.
  - FIFO contents are unaffected.
- The block contains no combinational path from RX inputs to DATA_OUT or DATA_VALID.

Test Plan:
- BAUD_SELECT=3'b101 (MASK=8'h6D), RX_VALID pulse with RX_DATA=8'h2C → next cycle DATA_VALID=1, DATA_OUT=8'h41, FIFO_COUNT=1; DATA_READY=1 for one cycle → DATA_VALID=0, FIFO_COUNT=0.
- BAUD_SELECT=3'b000, push 8'h11,8'h22,8'h33,8'h44 with DATA_READY=0, then push 8'h55 → FIFO_COUNT=4, OVERFLOW=1; drain yields 11,22,33,44 in order (pointer wrap check).
- FIFO full, RX_VALID with 8'h66 in the same cycle as a pop, key 0 → FIFO_COUNT stays 4, OVERFLOW stays 0, and 8'h66 is the 4th byte out after the pop.
- RX_VALID with RX_PERROR=1 on a full FIFO → ERR_COUNT increments by 1, OVERFLOW unchanged; drive 300 error strobes → ERR_COUNT=8'hFF; STATUS_CLR=1 → ERR_COUNT=0.
- Push 8'hA5 with BAUD_SELECT=3'b111 (MASK=8'hFF), then change BAUD_SELECT to 3'b000 before the pop → DATA_OUT=8'h5A.
- With FIFO_COUNT=3, assert reset asynchronously between edges → DATA_VALID=0 and FIFO_COUNT=0 immediately; after release, no output until a new RX_VALID.
